serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor; the inverse arithmetic path to the team's ripple adders.
- Computes diff = a - b - bin over WIDTH cycles, using one full-subtractor cell and a borrow flip-flop.
- Serves area-constrained datapaths where multi-cycle latency is acceptable.
- Start/busy/done handshake toward the issuing controller.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when diff/borrow_out become valid.
- diff  output  WIDTH  difference result.
- borrow_out  output  1  final borrow; 1 means unsigned a < b + bin.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst=1: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, bit counter=0, borrow flop=0, operand registers=0.
- Reset mid-operation aborts the subtraction immediately. No done pulse is issued for the aborted operation.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on start=1, load a, b and borrow flop<=bin; counter<=WIDTH-1; go to SHIFT.
- SHIFT: busy=1. Each cycle, with ai=a_reg[0], bi=b_reg[0], br=borrow flop:
  - d = ai^bi^br
  - br_next = (~ai&bi) | (~(ai^bi)&br)
  - shift a_reg and b_reg right by 1; shift d into the result register at its MSB.
  - counter decrements by 1. When counter=0 on a SHIFT cycle, go to DONE.
- DONE: busy=0, done=1 for exactly one cycle. Update diff from the result register and borrow_out from the final borrow.
  - start=1 in DONE is accepted: load as in IDLE and go to SHIFT.
  - Otherwise go to IDLE.
- Latency: start accepted at edge k; SHIFT occupies edges k+1..k+WIDTH; done=1 in the cycle following edge k+WIDTH.
- Throughput: one operation per WIDTH+1 cycles.
- diff and borrow_out hold their values from DONE until the next DONE or reset. They do not change while busy.
- start while busy=1 is ignored; there is no queueing.
- a, b and bin changing while busy have no effect.
- All arithmetic is modulo 2^WIDTH; there are no saturation semantics.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit), two's-complement signed overflow.
  - ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb), where a_msb and b_msb are captured at acceptance.
  - ovf updates with diff in DONE, holds otherwise, and resets to 0.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg:
  - state typedef with IDLE, SHIFT, DONE
  - counter width constant CNT_W = $clog2(WIDTH)
- Natural sub-module: full_subtractor. Purely combinational cell with inputs ai, bi, br and outputs d, br_next, instantiated once per datapath.
- serial_subtractor holds the FSM, shift registers, counter, and borrow and result registers.

Test Plan (WIDTH=8):
- a=0x35, b=0x12, bin=0, start pulse -> busy for 8 cycles; done on the 9th cycle after acceptance; diff=0x23, borrow_out=0.
- a=0x12, b=0x35, bin=0 -> diff=0xDD, borrow_out=1; with SERIAL_SUB_OVF_EN, ovf=0.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow_out=1. Then a=0x80, b=0x01, bin=0 -> diff=0x7F, borrow_out=0, ovf=1 when the macro is enabled.
- Accept a=0x35/b=0x12, then assert start with a=0xFF/b=0x00 during SHIFT -> ignored; result remains 0x23. Then start in the DONE cycle with a=0x10, b=0x01 -> accepted back-to-back; next result diff=0x0F.
- rst asserted at SHIFT cycle 4 -> busy, done, diff and borrow_out are 0 immediately. After release, a new a=0x09, b=0x03 -> diff=0x06 and exactly one done pulse.
- Random sweep of 1000 operands plus bin, checked against a behavioural model: {borrow_out,diff} == ({1'b0,a}-{1'b0,b}-bin) taken as WIDTH+1 bits.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Provides the sequencer state type and the bit-counter width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width for a given operand width; never narrower than 1 bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = ai - bi - br, with borrow out.
module full_subtractor (
    input  logic ai,
    input  logic bi,
    input  logic br,
    output logic d,
    output logic br_next
);

    // Difference bit and borrow generate/propagate.
    always_comb begin
        d       = ai ^ bi ^ br;
        br_next = (~ai & bi) | (~(ai ^ bi) & br);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles.
// Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow output ovf.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res;
    logic             br;
    logic             d;
    logic             br_n;
    logic [WIDTH-1:0] res_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor u_fs (
        .ai      (a_reg[0]),
        .bi      (b_reg[0]),
        .br      (br),
        .d       (d),
        .br_next (br_n)
    );

    // Result register after shifting in the current difference bit at the MSB.
    always_comb begin
        res_next = {d, res[WIDTH-1:1]};
    end

    // Sequencer, operand/result shift registers and registered handshake outputs.
    // The last SHIFT edge publishes diff/borrow_out directly so they are valid with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            res        <= '0;
            br         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        br    <= bin;
                        cnt   <= CW'(WIDTH - 1);
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    res   <= res_next;
                    br    <= br_n;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= br_n;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for done; returns edges to done and busy samples.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         output int lat, output int nbusy);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        nbusy = 0;
        while (!done && lat < 30) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
    endtask

    int lat, nbusy, extra;
    logic [8:0] exp9;
    logic [7:0] ra, rb;
    logic       rbin;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", borrow_out, 0);
        rst = 1'b0;
        tick();

        // 0x35 - 0x12
        do_op(8'h35, 8'h12, 1'b0, lat, nbusy);
        check("t1_latency", lat, 8);
        check("t1_busy_cycles", nbusy, 8);
        check("t1_diff", diff, 32'h23);
        check("t1_bout", borrow_out, 0);
        tick();
        check("t1_done_pulse", done, 0);

        // 0x12 - 0x35 wraps
        do_op(8'h12, 8'h35, 1'b0, lat, nbusy);
        check("t2_diff", diff, 32'hDD);
        check("t2_bout", borrow_out, 1);
`ifdef SERIAL_SUB_OVF_EN
        check("t2_ovf", ovf, 0);
`endif
        tick();

        // 0 - 0 - 1
        do_op(8'h00, 8'h00, 1'b1, lat, nbusy);
        check("t3_diff", diff, 32'hFF);
        check("t3_bout", borrow_out, 1);
        tick();

        // 0x80 - 0x01 signed overflow
        do_op(8'h80, 8'h01, 1'b0, lat, nbusy);
        check("t4_diff", diff, 32'h7F);
        check("t4_bout", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("t4_ovf", ovf, 1);
`endif
        tick();

        // start during SHIFT is ignored
        a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("t5_diff_hold", diff, 32'h7F);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        check("t5_latency", lat, 3);
        check("t5_diff", diff, 32'h23);
        // back-to-back start in the DONE cycle
        do_op(8'h10, 8'h01, 1'b0, lat, nbusy);
        check("t6_latency", lat, 8);
        check("t6_diff", diff, 32'h0F);
        check("t6_bout", borrow_out, 0);
        tick();

        // asynchronous reset mid-operation
        a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("t7_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        check("t7_busy", busy, 0);
        check("t7_done", done, 0);
        check("t7_diff", diff, 0);
        check("t7_bout", borrow_out, 0);
        tick();
        rst = 1'b0;
        tick();
        do_op(8'h09, 8'h03, 1'b0, lat, nbusy);
        check("t8_latency", lat, 8);
        check("t8_diff", diff, 32'h06);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) extra++;
        end
        check("t8_single_done", extra, 0);

        // random sweep against {borrow_out,diff} = {0,a}-{0,b}-bin
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            exp9 = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
            do_op(ra, rb, rbin, lat, nbusy);
            if (lat != 8) check("rnd_latency", lat, 8);
            check("rnd_result", {borrow_out, diff}, {23'b0, exp9});
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
